uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered 8N1 UART transmitter with a valid/ready byte FIFO.
//               Optional even-parity bit when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int BYTE         = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              areset,
    input  logic [BYTE-1:0]                   data_in,
    input  logic                              data_valid,
    output logic                              data_ready,
    output logic                              data_out,
    output logic                              tx_busy,
    output logic                              tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(BYTE + 1);

    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(BYTE - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [BYTE-1:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [2:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [BYTE-1:0]     r_shift;
    logic                r_line;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    logic            w_push;
    logic            w_pop;
    logic            w_baud_end;
    logic [BYTE-1:0] w_head;
    logic [BYTE-1:0] w_shift_next;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_shift_next = r_shift >> 1;
    assign w_baud_end   = (r_baud == c_BAUD_LAST);
    assign data_ready   = (r_count < c_FULL);
    assign w_push       = data_valid && data_ready;
    // A pop only ever happens when the shift register is (re)loaded.
    assign w_pop        = (r_count != '0) &&
                          ((r_state == c_ST_IDLE) || ((r_state == c_ST_STOP) && w_baud_end));

    assign data_out   = r_line;
    assign tx_busy    = (r_state != c_ST_IDLE);
    assign tx_done    = (r_state == c_ST_STOP) && w_baud_end;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state   <= c_ST_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_line    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
            if (w_pop) begin
                r_shift   <= w_head;
                r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                r_parity  <= ^w_head;
`endif
            end
            case (r_state)
                c_ST_IDLE: begin
                    r_baud <= '0;
                    r_line <= 1'b1;
                    if (w_pop) begin
                        r_state <= c_ST_START;
                        r_line  <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_baud_end) begin
                        r_state <= c_ST_DATA;
                        r_line  <= r_shift[0];
                    end
                end
                c_ST_DATA: begin
                    if (w_baud_end) begin
                        if (r_bit_cnt == c_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= c_ST_PARITY;
                            r_line  <= r_parity;
`else
                            r_state <= c_ST_STOP;
                            r_line  <= 1'b1;
`endif
                        end else begin
                            r_shift   <= w_shift_next;
                            r_line    <= w_shift_next[0];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_ST_PARITY: begin
                    if (w_baud_end) begin
                        r_state <= c_ST_STOP;
                        r_line  <= 1'b1;
                    end
                end
`endif
                c_ST_STOP: begin
                    // Chain straight into the next start bit when a byte is waiting.
                    if (w_baud_end) begin
                        if (w_pop) begin
                            r_state <= c_ST_START;
                            r_line  <= 1'b0;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_line  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_line  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo against a queue-based
//               line model (frame expanded to per-cycle line values).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
    localparam int BYTE  = 8;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = BYTE + 3;
`else
    localparam int NBITS = BYTE + 2;
`endif
    localparam int FRAME = NBITS * CPB;
    localparam int DRAIN = (DEPTH + 2) * FRAME + 20;

    logic       clk        = 1'b0;
    logic       areset     = 1'b1;
    logic [7:0] data_in    = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       data_out;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    uart_tx_fifo #(
        .BYTE         (BYTE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_out   (data_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // Model: mq holds queued bytes, lq holds line values for upcoming cycles.
    logic [7:0] mq[$];
    logic       lq[$];
    int         m_pre;
    bit         m_push;

    task automatic load_frame(input logic [7:0] b);
        for (int i = 0; i < CPB; i++) lq.push_back(1'b0);
        for (int k = 0; k < BYTE; k++)
            for (int i = 0; i < CPB; i++) lq.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
        for (int i = 0; i < CPB; i++) lq.push_back(^b);
`endif
        for (int i = 0; i < CPB; i++) lq.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        if (areset) begin
            mq.delete();
            lq.delete();
        end else begin
            m_pre  = mq.size();
            m_push = data_valid && (m_pre < DEPTH);
            if (lq.size() > 0) void'(lq.pop_front());
            if (lq.size() == 0 && m_pre > 0) load_frame(mq.pop_front());
            if (m_push) mq.push_back(data_in);
        end
    end

    // {data_out, tx_busy, tx_done, data_ready, fifo_count}
    function automatic logic [6:0] exp_vec();
        logic ln;
        ln = (lq.size() > 0) ? lq[0] : 1'b1;
        return {ln, (lq.size() > 0), (lq.size() == 1), (mq.size() < DEPTH), 3'(mq.size())};
    endfunction

    task automatic test_reset();
        areset = 1'b1; data_valid = 1'b1; data_in = 8'h5A;
        repeat (2) @(negedge clk);
        ntests++;
        if ({data_out, tx_busy, tx_done, data_ready, fifo_count} !== 7'b1001000) begin
            nfail++;
            $display("FAIL reset_state got=%b exp=%b", {data_out, tx_busy, tx_done, data_ready, fifo_count}, 7'b1001000);
        end
        areset = 1'b0; data_valid = 1'b0;
        repeat (3) @(negedge clk);
        ntests++;
        if (fifo_count !== 3'd0 || data_out !== 1'b1 || tx_busy !== 1'b0) begin
            nfail++;
            $display("FAIL reset_nothing_queued got cnt=%0d line=%b busy=%b exp cnt=0 line=1 busy=0", fifo_count, data_out, tx_busy);
        end
    endtask

    task automatic test_single_byte();
        int   busy_n = 0, done_n = 0, start_c = -1, done_c = -1;
        logic smp [$];
        logic [7:0] dec;
        data_in = 8'hA5; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int c = 0; c < FRAME + 10; c++) begin
            ntests++;
            if ({data_out, tx_busy, tx_done, data_ready, fifo_count} !== exp_vec()) begin
                nfail++;
                $display("FAIL single_byte cyc=%0d got=%b exp=%b", c, {data_out, tx_busy, tx_done, data_ready, fifo_count}, exp_vec());
            end
            if (tx_busy === 1'b1) begin
                if (start_c < 0) start_c = c;
                busy_n++;
                smp.push_back(data_out);
            end
            if (tx_done === 1'b1) begin
                done_n++;
                done_c = c;
            end
            @(negedge clk);
        end
        ntests++;
        if (busy_n != FRAME || done_n != 1 || (done_c - start_c) != FRAME - 1) begin
            nfail++;
            $display("FAIL single_byte_timing got busy=%0d done=%0d done_off=%0d exp busy=%0d done=1 done_off=%0d",
                     busy_n, done_n, done_c - start_c, FRAME, FRAME - 1);
        end
        dec = 8'h00;
        for (int k = 0; k < BYTE; k++)
            if ((k + 1) * CPB + CPB / 2 < smp.size()) dec[k] = smp[(k + 1) * CPB + CPB / 2];
        ntests++;
        if (smp.size() != FRAME || dec !== 8'hA5 || smp[CPB / 2] !== 1'b0 || smp[FRAME - 1] !== 1'b1) begin
            nfail++;
            $display("FAIL single_byte_decode got byte=%h len=%0d exp byte=a5 len=%0d", dec, smp.size(), FRAME);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        int idx = 0, busy_n = 0, done_n = 0;
        bit will = 0, seen5 = 0;
        for (int c = 0; c < 6 * FRAME + 40; c++) begin
            data_valid = (idx < 6);
            data_in    = (idx < 6) ? bytes[idx] : 8'h00;
            will       = data_valid && data_ready;
            @(negedge clk);
            if (will) idx++;
            ntests++;
            if ({data_out, tx_busy, tx_done, data_ready, fifo_count} !== exp_vec()) begin
                nfail++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, {data_out, tx_busy, tx_done, data_ready, fifo_count}, exp_vec());
            end
            if (idx == 5 && !seen5) begin
                seen5 = 1;
                ntests++;
                if (fifo_count !== 3'd4 || data_ready !== 1'b0) begin
                    nfail++;
                    $display("FAIL back_to_back_full got cnt=%0d ready=%b exp cnt=4 ready=0", fifo_count, data_ready);
                end
            end
            busy_n += int'(tx_busy);
            done_n += int'(tx_done);
        end
        data_valid = 1'b0;
        ntests++;
        if (idx != 6 || busy_n != 6 * FRAME || done_n != 6) begin
            nfail++;
            $display("FAIL back_to_back_totals got acc=%0d busy=%0d done=%0d exp acc=6 busy=%0d done=6", idx, busy_n, done_n, 6 * FRAME);
        end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
        int c;
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1; data_in = bytes[i];
            @(negedge clk);
        end
        data_valid = 1'b0;
        c = 0;
        while (!(lq.size() == 1 && mq.size() == 2) && c < 2 * FRAME) begin
            ntests++;
            if ({data_out, tx_busy, tx_done, data_ready, fifo_count} !== exp_vec()) begin
                nfail++;
                $display("FAIL simul_wait cyc=%0d got=%b exp=%b", c, {data_out, tx_busy, tx_done, data_ready, fifo_count}, exp_vec());
            end
            @(negedge clk);
            c++;
        end
        ntests++;
        if (c >= 2 * FRAME || tx_done !== 1'b1 || fifo_count !== 3'd2) begin
            nfail++;
            $display("FAIL simul_stop_reached got done=%b cnt=%0d cyc=%0d exp done=1 cnt=2", tx_done, fifo_count, c);
        end
        data_valid = 1'b1; data_in = 8'h44;
        @(negedge clk);
        data_valid = 1'b0;
        ntests++;
        if (fifo_count !== 3'd2 || data_out !== 1'b0 || tx_busy !== 1'b1) begin
            nfail++;
            $display("FAIL simul_push_pop got cnt=%0d line=%b busy=%b exp cnt=2 line=0 busy=1", fifo_count, data_out, tx_busy);
        end
        for (c = 0; c < DRAIN && (lq.size() > 0 || mq.size() > 0); c++) begin
            ntests++;
            if ({data_out, tx_busy, tx_done, data_ready, fifo_count} !== exp_vec()) begin
                nfail++;
                $display("FAIL simul_drain cyc=%0d got=%b exp=%b", c, {data_out, tx_busy, tx_done, data_ready, fifo_count}, exp_vec());
            end
            @(negedge clk);
        end
        ntests++;
        if (tx_busy !== 1'b0 || fifo_count !== 3'd0) begin
            nfail++;
            $display("FAIL simul_idle got busy=%b cnt=%0d exp busy=0 cnt=0", tx_busy, fifo_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bytes [3] = '{8'h3C, 8'hAA, 8'h55};
        int c, done_n = 0, low_n = 0;
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1; data_in = bytes[i];
            @(negedge clk);
        end
        data_valid = 1'b0;
        c = 0;
        while (!(lq.size() > 0 && FRAME - lq.size() == 4 * CPB + 1) && c < 2 * FRAME) begin
            ntests++;
            if ({data_out, tx_busy, tx_done, data_ready, fifo_count} !== exp_vec()) begin
                nfail++;
                $display("FAIL midreset_wait cyc=%0d got=%b exp=%b", c, {data_out, tx_busy, tx_done, data_ready, fifo_count}, exp_vec());
            end
            @(negedge clk);
            c++;
        end
        ntests++;
        if (c >= 2 * FRAME || fifo_count !== 3'd2 || data_out !== 1'b1) begin
            nfail++;
            $display("FAIL midreset_bit3 got cnt=%0d line=%b cyc=%0d exp cnt=2 line=1", fifo_count, data_out, c);
        end
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        ntests++;
        if ({data_out, tx_busy, tx_done, data_ready, fifo_count} !== 7'b1001000) begin
            nfail++;
            $display("FAIL midreset_abort got=%b exp=%b", {data_out, tx_busy, tx_done, data_ready, fifo_count}, 7'b1001000);
        end
        for (c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            done_n += int'(tx_done);
            low_n  += int'(data_out !== 1'b1);
        end
        ntests++;
        if (done_n != 0 || low_n != 0 || tx_busy !== 1'b0) begin
            nfail++;
            $display("FAIL midreset_silent got done=%0d low=%0d busy=%b exp done=0 low=0 busy=0", done_n, low_n, tx_busy);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic smp [$];
        data_valid = 1'b1; data_in = 8'h07;
        @(negedge clk);
        data_in = 8'hA5;
        @(negedge clk);
        data_valid = 1'b0;
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            if (tx_busy === 1'b1) smp.push_back(data_out);
            @(negedge clk);
        end
        ntests++;
        if (smp.size() != 2 * 44 || smp[9 * CPB + CPB / 2] !== 1'b1 || smp[44 + 9 * CPB + CPB / 2] !== 1'b0) begin
            nfail++;
            $display("FAIL parity got len=%0d exp len=88 with parity bits 1,0", smp.size());
        end
    endtask
`endif

    task automatic test_random();
        int c;
        for (c = 0; c < 400; c++) begin
            data_valid = 1'($urandom_range(0, 1));
            data_in    = 8'($urandom);
            areset     = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            ntests++;
            if ({data_out, tx_busy, tx_done, data_ready, fifo_count} !== exp_vec()) begin
                nfail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, {data_out, tx_busy, tx_done, data_ready, fifo_count}, exp_vec());
            end
        end
        areset = 1'b0; data_valid = 1'b0;
        for (c = 0; c < DRAIN && (lq.size() > 0 || mq.size() > 0); c++) begin
            @(negedge clk);
            ntests++;
            if ({data_out, tx_busy, tx_done, data_ready, fifo_count} !== exp_vec()) begin
                nfail++;
                $display("FAIL random_drain cyc=%0d got=%b exp=%b", c, {data_out, tx_busy, tx_done, data_ready, fifo_count}, exp_vec());
            end
        end
        @(negedge clk);
        ntests++;
        if (tx_busy !== 1'b0 || fifo_count !== 3'd0 || data_out !== 1'b1) begin
            nfail++;
            $display("FAIL random_idle got busy=%b cnt=%0d line=%b exp busy=0 cnt=0 line=1", tx_busy, fifo_count, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_simul_push_pop();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
